serial_subtractor: RTL

//   Multi-cycle N-bit unsigned subtractor: diff = a - b - b_in (mod 2^N), processed M bits per cycle.

---
 rtl/serial_sub_pkg.sv | 17 +
 rtl/sub_slice.sv | 26 ++
 rtl/serial_subtractor.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the serial subtractor.
//   sub_state_t : control FSM states (IDLE, RUN, DONE)
//   cnt_width() : slice-counter width, never below 1 bit
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  // A single-slice build still needs a 1-bit counter to hold a legal vector.
  function automatic int unsigned cnt_width(input int unsigned slices);
    return (slices > 1) ? $clog2(slices) : 1;
  endfunction

endpackage

// File: rtl/sub_slice.sv
// Combinational M-bit subtract slice: {b_out, d} = a - b - b_in.
//   a, b  : M-bit slice operands
//   b_in  : borrow into the slice
//   d     : M-bit slice difference
//   b_out : borrow out of the slice (1 iff a < b + b_in)
module sub_slice #(
  parameter int unsigned M = 8
) (
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  input  logic         b_in,
  output logic [M-1:0] d,
  output logic         b_out
);

  logic [M:0] res;

  // One extra bit holds the sign of the true difference, i.e. the borrow.
  always_comb begin
    res = {1'b0, a} - {1'b0, b} - (M+1)'(b_in);
  end

  assign d     = res[M-1:0];
  assign b_out = res[M];

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle N-bit unsigned subtractor, diff = a - b - b_in (mod 2^N),
// one M-bit slice per cycle, LSB slice first.
// Both borrow-in variants of each slice are computed; the registered
// borrow picks one.
//   clk, rst            : rising-edge clock, async active-high reset
//   in_valid / in_ready : operand handshake (in_ready high only in IDLE)
//   a, b, b_in          : minuend, subtrahend, borrow-in
//   out_valid/out_ready : result handshake
//   diff, b_out         : result and final borrow
//   ovf                 : signed overflow, present only with SERIAL_SUB_OVF_EN
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned N = 32,
  parameter int unsigned M = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         b_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] diff,
  output logic         b_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int unsigned NS    = N / M;
  localparam int unsigned CNT_W = cnt_width(NS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NS - 1);

  if (N % M != 0) begin : g_bad_cfg
    $error("serial_subtractor: N must be a multiple of M");
  end

  sub_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic [N-1:0]   diff_q, diff_d;
  logic           borrow_q, borrow_d;
  logic           out_valid_q, out_valid_d;
`ifdef SERIAL_SUB_OVF_EN
  logic           ovf_q, ovf_d;
`endif

  logic [M-1:0] a_sl, b_sl, d0, d1, sl_diff;
  logic         bo0, bo1, sl_borrow;

  assign a_sl = a_q[cnt_q*M +: M];
  assign b_sl = b_q[cnt_q*M +: M];

  sub_slice #(.M(M)) u_slice_b0 (
    .a(a_sl), .b(b_sl), .b_in(1'b0), .d(d0), .b_out(bo0)
  );

  sub_slice #(.M(M)) u_slice_b1 (
    .a(a_sl), .b(b_sl), .b_in(1'b1), .d(d1), .b_out(bo1)
  );

  // Registered borrow selects between the precomputed slice results.
  assign sl_diff   = borrow_q ? d1  : d0;
  assign sl_borrow = borrow_q ? bo1 : bo0;

  // State register and datapath flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      diff_q      <= '0;
      borrow_q    <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      diff_q      <= diff_d;
      borrow_q    <= borrow_d;
      out_valid_q <= out_valid_d;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    diff_d      = diff_q;
    borrow_d    = borrow_q;
    out_valid_d = out_valid_q;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d       = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d      = a;
          b_d      = b;
          borrow_d = b_in;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        diff_d[cnt_q*M +: M] = sl_diff;
        borrow_d             = sl_borrow;
        if (cnt_q == LAST_CNT) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
`ifdef SERIAL_SUB_OVF_EN
          // Top slice MSB is diff[N-1].
          ovf_d = (a_q[N-1] ^ b_q[N-1]) & (a_q[N-1] ^ sl_diff[M-1]);
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign b_out     = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule
